// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding and constants for the scalar core sequencer
package core_pkg;

    localparam int STATE_W = 3;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// rtl/ack_watchdog.sv - stall counter that flags a request left unacknowledged for TIMEOUT cycles
module ack_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic pending,
    input  logic ack,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? int'(TIMEOUT) - 1 : 0;

    logic [CNT_W-1:0] wait_cnt;

    // Counter idles at zero whenever nothing is outstanding, so each new request starts fresh.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!pending || ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (TIMEOUT != 0) && pending && !ack && (wait_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multicycle fetch/decode/exec/mem/wb control FSM with PC, retire count and traps
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               ir_we,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               dmem_req,
    input  logic               dmem_ack,
    input  logic               branch,
    input  logic [31:0]        branch_addr,
    input  logic               halt,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        pc,
    output logic               retire,
    output logic [31:0]        instret,
    output logic               halted,
    output logic               error
);

    state_e state_q;
    logic   access;
    logic   imem_pend;
    logic   dmem_pend;
    logic   wd_ack;
    logic   timeout;
    logic   wb_fault;

    assign access    = mem_read | mem_write;
    assign imem_pend = (state_q == ST_FETCH);
    assign dmem_pend = (state_q == ST_MEM) && access;
    assign wd_ack    = imem_pend ? imem_ack : dmem_ack;
    assign wb_fault  = branch && pc_misaligned(branch_addr);

    ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .pending (imem_pend | dmem_pend),
        .ack     (wd_ack),
        .timeout (timeout)
    );

    // Requests are abandoned the moment reset asserts, not on the following edge.
    assign imem_req = imem_pend & rst;
    assign dmem_req = dmem_pend & rst;
    assign ir_we    = imem_req & imem_ack;
    assign retire   = rst && (state_q == ST_WB) && !wb_fault;
    assign state    = state_q;
    assign halted   = (state_q == ST_HALT);
    assign error    = (state_q == ST_ERR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc      <= RESET_PC;
            instret <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state_q <= ST_DECODE;
                    end else if (timeout) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_DECODE: state_q <= halt ? ST_HALT : ST_EXEC;
                ST_EXEC:   state_q <= ST_MEM;
                ST_MEM: begin
                    if (!access || dmem_ack) begin
                        state_q <= ST_WB;
                    end else if (timeout) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_WB: begin
                    if (wb_fault) begin
                        state_q <= ST_ERR;
                    end else begin
                        state_q <= ST_FETCH;
                        pc      <= branch ? branch_addr : pc + PC_STEP;
                        instret <= instret + 32'd1;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                ST_ERR:  state_q <= ST_ERR;
                default: state_q <= ST_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized transaction-level bench for core_sequencer
module tb_core_sequencer;

    localparam int          T_OUT  = 8;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3,
                            S_WB = 4, S_HALT = 5, S_ERR = 6, S_UNKNOWN = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, ir_we;
    logic        mem_read, mem_write, dmem_req, dmem_ack;
    logic        branch, halt;
    logic [31:0] branch_addr;
    logic [2:0]  state;
    logic [31:0] pc, instret;
    logic        retire, halted, error;

    always #5 clk = ~clk;

    core_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(T_OUT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .mem_read(mem_read), .mem_write(mem_write),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .branch(branch), .branch_addr(branch_addr), .halt(halt),
        .state(state), .pc(pc), .retire(retire), .instret(instret),
        .halted(halted), .error(error)
    );

    typedef struct {
        logic        rst, imem_ack, dmem_ack, mem_read, mem_write, branch, halt;
        logic [31:0] branch_addr;
        bit          chk;
        logic [2:0]  e_state;
        logic [31:0] e_pc, e_instret;
        logic        e_imem_req, e_dmem_req, e_ir_we, e_retire, e_halted, e_error;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    bit          cur_valid = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int          m_state;
    logic [31:0] m_pc, m_instret;
    logic        cur_rd, cur_wr, cur_br;
    logic [31:0] cur_addr;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic rec_t base(input int st);
        rec_t r;
        r.rst         = 1'b1;
        r.imem_ack    = 1'($urandom_range(0, 1));
        r.dmem_ack    = 1'($urandom_range(0, 1));
        r.halt        = 1'($urandom_range(0, 1));
        r.mem_read    = cur_rd;
        r.mem_write   = cur_wr;
        r.branch      = cur_br;
        r.branch_addr = cur_addr;
        r.chk         = (st != S_UNKNOWN);
        r.e_state     = 3'(st);
        r.e_pc        = m_pc;
        r.e_instret   = m_instret;
        r.e_imem_req  = 1'b0;
        r.e_dmem_req  = 1'b0;
        r.e_ir_we     = 1'b0;
        r.e_retire    = 1'b0;
        r.e_halted    = (st == S_HALT);
        r.e_error     = (st == S_ERR);
        return r;
    endfunction

    task automatic gen_reset(input int n);
        rec_t r;
        r = base(m_state);
        r.rst = 1'b0;
        q.push_back(r);
        m_state   = S_FETCH;
        m_pc      = RST_PC;
        m_instret = 32'd0;
        for (int i = 1; i < n; i++) begin
            r = base(S_FETCH);
            r.rst = 1'b0;
            q.push_back(r);
        end
    endtask

    task automatic gen_idle(input int n, input bit force_ack);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = base(m_state);
            if (force_ack) begin
                r.imem_ack = 1'b1;
                r.dmem_ack = 1'b1;
            end
            q.push_back(r);
        end
    endtask

    // One instruction: FETCH stalls l cycles, MEM stalls d cycles when accessing.
    task automatic gen_instr(input int l, input bit rd, input bit wr, input int d,
                             input bit br, input logic [31:0] addr, input bit hlt,
                             input int abort_at);
        rec_t r;
        cur_rd = rd; cur_wr = wr; cur_br = br; cur_addr = addr;
        for (int i = 0; i <= l && i < T_OUT; i++) begin
            r = base(S_FETCH);
            r.imem_ack   = (i == l);
            r.e_imem_req = 1'b1;
            r.e_ir_we    = (i == l);
            q.push_back(r);
        end
        if (l >= T_OUT) begin
            m_state = S_ERR;
            return;
        end
        r = base(S_DECODE);
        r.halt = hlt;
        q.push_back(r);
        if (hlt) begin
            m_state = S_HALT;
            return;
        end
        q.push_back(base(S_EXEC));
        if (rd || wr) begin
            for (int j = 0; j <= d && j < T_OUT; j++) begin
                if (j == abort_at) begin
                    m_state = S_MEM;
                    gen_reset(1);
                    return;
                end
                r = base(S_MEM);
                r.dmem_ack   = (j == d);
                r.e_dmem_req = 1'b1;
                q.push_back(r);
            end
            if (d >= T_OUT) begin
                m_state = S_ERR;
                return;
            end
        end else begin
            q.push_back(base(S_MEM));
        end
        r = base(S_WB);
        r.e_retire = !(br && addr[1:0] != 2'b00);
        q.push_back(r);
        if (br && addr[1:0] != 2'b00) begin
            m_state = S_ERR;
        end else begin
            m_pc      = br ? addr : m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
            m_state   = S_FETCH;
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid && cur.chk) begin
            chk("state",    32'(state),    32'(cur.e_state));
            chk("pc",       pc,            cur.e_pc);
            chk("instret",  instret,       cur.e_instret);
            chk("imem_req", 32'(imem_req), 32'(cur.e_imem_req));
            chk("dmem_req", 32'(dmem_req), 32'(cur.e_dmem_req));
            chk("ir_we",    32'(ir_we),    32'(cur.e_ir_we));
            chk("retire",   32'(retire),   32'(cur.e_retire));
            chk("halted",   32'(halted),   32'(cur.e_halted));
            chk("error",    32'(error),    32'(cur.e_error));
        end
    end

    task automatic run_queue();
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            cur         = q.pop_front();
            rst         = cur.rst;
            imem_ack    = cur.imem_ack;
            dmem_ack    = cur.dmem_ack;
            mem_read    = cur.mem_read;
            mem_write   = cur.mem_write;
            branch      = cur.branch;
            branch_addr = cur.branch_addr;
            halt        = cur.halt;
            cur_valid   = 1;
            cyc++;
        end
        @(negedge clk);
        #1;
        cur_valid = 0;
    endtask

    initial begin
        int n0;
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        branch = 1'b0; branch_addr = 32'd0; halt = 1'b0;
        m_state = S_UNKNOWN; m_pc = 32'd0; m_instret = 32'd0;
        cur_rd = 1'b0; cur_wr = 1'b0; cur_br = 1'b0; cur_addr = 32'd0;

        gen_reset(2);
        n0 = q.size();
        gen_instr(0, 0, 0, 0, 0, 32'd0, 0, -1);
        chk("lit_cpi_alu", q.size() - n0, 5);
        chk("lit_pc_alu", m_pc, 32'h4);
        chk("lit_instret_alu", m_instret, 32'd1);

        n0 = q.size();
        gen_instr(0, 1, 0, 3, 0, 32'd0, 0, -1);
        chk("lit_cpi_load", q.size() - n0, 8);
        chk("lit_pc_load", m_pc, 32'h8);

        gen_instr(1, 0, 1, 2, 1, 32'h40, 0, -1);
        chk("lit_pc_branch", m_pc, 32'h40);
        gen_instr(0, 0, 0, 0, 1, 32'h42, 0, -1);
        chk("lit_pc_misaligned", m_pc, 32'h40);
        chk("lit_state_misaligned", m_state, S_ERR);
        gen_idle(4, 0);
        gen_reset(2);

        n0 = q.size();
        gen_instr(T_OUT + 5, 0, 0, 0, 0, 32'd0, 0, -1);
        chk("lit_fetch_timeout_cycles", q.size() - n0, T_OUT);
        gen_idle(4, 1);
        gen_reset(2);

        gen_instr(2, 1, 1, T_OUT + 3, 0, 32'd0, 0, -1);
        chk("lit_state_mem_timeout", m_state, S_ERR);
        gen_idle(3, 1);
        gen_reset(2);

        gen_instr(0, 0, 0, 0, 0, 32'd0, 1, -1);
        gen_idle(4, 1);
        gen_reset(2);
        gen_instr(0, 0, 0, 0, 0, 32'd0, 0, -1);
        gen_instr(0, 1, 0, 5, 0, 32'd0, 0, 2);
        chk("lit_pc_after_mem_reset", m_pc, RST_PC);

        for (int k = 0; k < 150; k++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a    = $urandom & 32'hFFFF_FFFC;
            gen_instr($urandom_range(0, T_OUT - 1), kind[0], kind[1], $urandom_range(0, T_OUT - 1),
                      ($urandom_range(0, 3) == 0), a, 0, -1);
        end
        gen_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, -1);
        gen_instr(0, 0, 0, 0, 0, 32'd0, 0, -1);
        chk("lit_pc_wrap", m_pc, 32'h0);

        run_queue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
